// File: rtl/hvac_actuator_driver.sv
// HVAC actuator driver: sequences furnace, compressor and blower relays from
// thermostat requests with purge timing, minimum run time and compressor lockout.
module hvac_actuator_driver #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned FAN_DLY  = 3,
    parameter int unsigned FAN_POST = 5,
    parameter int unsigned MIN_ON   = 8,
    parameter int unsigned MIN_OFF  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       heat_req,
    input  logic       cool_req,
    input  logic       limit_fault,
    input  logic       fault_clear,
    output logic       furnace_on,
    output logic       compressor_on,
    output logic       fan_on,
    output logic       lockout,
    output logic       req_conflict,
    output logic       fault_latched,
    output logic [2:0] state_o
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_HEAT_IGN   = 3'd1;
    localparam logic [2:0] S_HEAT_RUN   = 3'd2;
    localparam logic [2:0] S_HEAT_PURGE = 3'd3;
    localparam logic [2:0] S_COOL_PRE   = 3'd4;
    localparam logic [2:0] S_COOL_RUN   = 3'd5;
    localparam logic [2:0] S_COOL_PURGE = 3'd6;
    localparam logic [2:0] S_FAULT      = 3'd7;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(FAN_DLY - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(FAN_POST - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] LOCK_INIT = CNT_W'(MIN_OFF);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] lock_q, lock_d;
    logic             furnace_q, furnace_d;
    logic             compressor_q, compressor_d;
    logic             fan_q, fan_d;
    logic             conflict_q, conflict_d;
    logic             fault_q, fault_d;
    logic             heat_eff, cool_eff;

    // Simultaneous heat and cool requests cancel each other out.
    assign heat_eff = heat_req & ~cool_req;
    assign cool_eff = cool_req & ~heat_req;

    always_comb begin
        state_d = state_q;
        if (limit_fault && (state_q != S_FAULT)) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (heat_eff)                        state_d = S_HEAT_IGN;
                    else if (cool_eff && (lock_q == '0)) state_d = S_COOL_PRE;
                end
                S_HEAT_IGN:   if (phase_q == PRE_LAST)  state_d = S_HEAT_RUN;
                S_HEAT_RUN:   if ((phase_q >= RUN_LAST) && !heat_eff) state_d = S_HEAT_PURGE;
                S_HEAT_PURGE: if (phase_q == POST_LAST) state_d = S_IDLE;
                S_COOL_PRE:   if (phase_q == PRE_LAST)  state_d = S_COOL_RUN;
                S_COOL_RUN:   if ((phase_q >= RUN_LAST) && !cool_eff) state_d = S_COOL_PURGE;
                S_COOL_PURGE: if (phase_q == POST_LAST) state_d = S_IDLE;
                S_FAULT:      if (fault_clear && !limit_fault) state_d = S_IDLE;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        if (state_d != state_q)   phase_d = '0;
        else if (phase_q == '1)   phase_d = phase_q;
        else                      phase_d = phase_q + CNT_W'(1);

        // Any departure from COOL_RUN, including into FAULT, restarts the lockout.
        if ((state_q == S_COOL_RUN) && (state_d != S_COOL_RUN)) lock_d = LOCK_INIT;
        else if (lock_q != '0)                                   lock_d = lock_q - CNT_W'(1);
        else                                                     lock_d = lock_q;
    end

    // Drives are decoded from the next state so they change on the same edge.
    always_comb begin
        furnace_d    = (state_d == S_HEAT_IGN) || (state_d == S_HEAT_RUN);
        compressor_d = (state_d == S_COOL_RUN);
        fan_d        = (state_d != S_IDLE) && (state_d != S_HEAT_IGN);
        fault_d      = (state_d == S_FAULT);
        conflict_d   = heat_req & cool_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            lock_q       <= LOCK_INIT;
            furnace_q    <= 1'b0;
            compressor_q <= 1'b0;
            fan_q        <= 1'b0;
            conflict_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            lock_q       <= lock_d;
            furnace_q    <= furnace_d;
            compressor_q <= compressor_d;
            fan_q        <= fan_d;
            conflict_q   <= conflict_d;
            fault_q      <= fault_d;
        end
    end

    assign furnace_on    = furnace_q;
    assign compressor_on = compressor_q;
    assign fan_on        = fan_q;
    assign lockout       = (lock_q != '0);
    assign req_conflict  = conflict_q;
    assign fault_latched = fault_q;
    assign state_o       = state_q;

endmodule

// File: doc/hvac_actuator_driver.md
Name: hvac_actuator_driver

Overview:
- Downstream end of the thermostat's heating/cooling request interface.
- Turns the heat/cool request levels into safe equipment drive signals: furnace burner, compressor and blower fan.
- Enforces fan pre/post-purge timing, a minimum run time and a compressor anti-short-cycle lockout.
- Latches furnace high-limit faults. Sits between the thermostat controller and the relay/GPIO drivers.

Parameters:
- CNT_W, 16, width of the phase counter and the lockout counter.
- FAN_DLY, 3, cycles the burner/fan pre-phase lasts before the main run phase (≥1).
- FAN_POST, 5, cycles of fan-only purge after a run (≥1).
- MIN_ON, 8, minimum cycles spent in a run state (≥1).
- MIN_OFF, 20, compressor lockout cycles after the compressor turns off or after reset (≥0).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- heat_req  in  1  heating request level from the thermostat
- cool_req  in  1  cooling request level from the thermostat
- limit_fault  in  1  furnace high-limit switch tripped (level)
- fault_clear  in  1  single-cycle pulse that acknowledges a latched fault
- furnace_on  out  1  burner relay drive
- compressor_on  out  1  compressor relay drive
- fan_on  out  1  blower relay drive
- lockout  out  1  compressor lockout counter is nonzero
- req_conflict  out  1  heat_req and cool_req are both high this cycle (registered)
- fault_latched  out  1  driver is in the FAULT state
- state_o  out  3  current state encoding, for debug

Behaviour:
- **States and encoding:** IDLE=0, HEAT_IGN=1, HEAT_RUN=2, HEAT_PURGE=3, COOL_PRE=4, COOL_RUN=5, COOL_PURGE=6, FAULT=7.
- **Output timing:** all outputs are registered and updated on the same edge as the state change. Request-to-output latency is 1 clock.
- **Reset:**
  - state=IDLE; furnace_on, compressor_on, fan_on, req_conflict and fault_latched all 0.
  - Lockout counter loads MIN_OFF, so lockout=1 when MIN_OFF>0.
- **Conflict:** when heat_req && cool_req, both requests are treated as deasserted and req_conflict=1.
- **Phase counter:** cleared on every state entry, increments each cycle and saturates at all-ones.
- **Lockout counter:** loaded with MIN_OFF on any exit from COOL_RUN, and on reset. Otherwise it decrements each cycle, stopping at 0.
- **Priority:** limit_fault=1 in any non-FAULT state transitions to FAULT next edge. This overrides MIN_ON and all other transitions.
- **IDLE:** all drives 0.
  - Effective heat → HEAT_IGN.
  - Else effective cool && lockout==0 → COOL_PRE.
  - Otherwise stay in IDLE.
- **HEAT_IGN:** furnace_on=1, fan_on=0. Lasts exactly FAN_DLY cycles, then → HEAT_RUN. A request drop during this state does not abort it.
- **HEAT_RUN:** furnace_on=1, fan_on=1. Leave when phase count ≥ MIN_ON-1 and effective heat==0, then → HEAT_PURGE.
- **HEAT_PURGE:** furnace_on=0, fan_on=1. Lasts exactly FAN_POST cycles, then → IDLE. It always completes, even if a request reasserts.
- **COOL_PRE:** fan_on=1, compressor_on=0. Lasts FAN_DLY cycles, then → COOL_RUN.
- **COOL_RUN:** compressor_on=1, fan_on=1. Same MIN_ON exit rule using effective cool, then → COOL_PURGE.
- **COOL_PURGE:** compressor_on=0, fan_on=1. Lasts FAN_POST cycles, then → IDLE.
- **FAULT:** furnace_on=0, compressor_on=0, fan_on=1, fault_latched=1.
  - Leave only on fault_clear=1 with limit_fault=0 in the same cycle, then → IDLE.
  - fault_clear while limit_fault=1 is ignored.
- **Mutual exclusion:** furnace_on and compressor_on are never both 1.
- **Reset mid-operation:** all drives drop asynchronously and the lockout counter reloads.

Test Plan:
- **Heat cycle:** release reset, heat_req=1 for 2 cycles then 0.
  - furnace_on rises edge 1; fan_on rises 3 cycles later.
  - furnace_on stays high 3+8 cycles total.
  - fan-only for 5 cycles, then IDLE with all drives 0.
- **Post-reset lockout:** cool_req=1 from reset release.
  - lockout=1 and compressor_on=0 for 20 cycles.
  - Then COOL_PRE: fan_on 3 cycles with compressor off, then compressor_on=1.
- **Short-cycle protection:** complete a cool cycle, reassert cool_req at the IDLE entry.
  - compressor_on stays 0 until 20 cycles after COOL_RUN exit, then COOL_PRE begins.
- **Conflict:** heat_req=cool_req=1 in IDLE for 10 cycles.
  - req_conflict=1 one cycle later; state stays IDLE; all drives 0.
- **Limit fault:** limit_fault=1 at HEAT_RUN cycle 2, before MIN_ON.
  - Next edge: furnace_on=0, fan_on=1, fault_latched=1, state_o=7.
  - fault_clear while limit_fault=1: no change.
  - Drop limit_fault, pulse fault_clear: IDLE, all 0.
- **Reset mid-COOL_RUN:** assert reset.
  - compressor_on and fan_on drop immediately.
  - After release, lockout=1 for 20 cycles; cool_req is ignored until then.
